bhargava_link_tx: RTL and testbench

Host-side link initiator for the bhargava UART protocol; it drives the receive pin of the bhargava board.
- Serializes an 8-byte DES key, then a mode byte, then a stream of MPEG bytes as UART frames (8 data bits, parity, one stop bit).
- Terminates the stream with one frame carrying deliberately inverted parity, which the far end treats as stream_end.
- Used in loopback test rigs and host-emulation bridges.

---
 rtl/bhargava_link_pkg.sv | 12 +
 rtl/bhargava_link_frame_ser.sv | 69 ++++++
 rtl/bhargava_link_tx.sv | 160 ++++++++++++++++
 tb/tb_bhargava_link_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bhargava_link_pkg.sv
// Shared types and constants for the bhargava host-side link transmitter.
package bhargava_link_pkg;

  typedef enum logic [2:0] {IDLE, KEY, MODE, DATA, END, FIN} state_t;

  localparam int FRAME_BITS = 11;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return (clk_freq * 1_000_000) / baud_rate;
  endfunction

endpackage

// File: rtl/bhargava_link_frame_ser.sv
// UART frame serializer: start bit, 8 data bits LSB first, parity, stop bit.
module link_frame_ser
  import bhargava_link_pkg::*;
#(
  parameter int    CLKS_PER_BIT = 781,
  parameter string PARITY       = "ODD"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_byte,
  input  logic       load,
  input  logic       par_inv,
  output logic       tx_out,
  output logic       ser_busy,
  output logic       ser_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);
  localparam bit               ODD_PAR  = (PARITY == "ODD");

  logic [CNT_W-1:0] clk_cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [9:0]       shift_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic             par_bit;

  assign par_bit = (ODD_PAR ? ~^data_byte : ^data_byte) ^ par_inv;

  // Start bit goes straight to the line; the rest waits in shift_reg.
  // A load is accepted during the final stop-bit cycle so frames run back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '1;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else if (load) begin
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= {1'b1, par_bit, data_byte};
      tx_reg      <= 1'b0;
      busy_reg    <= 1'b1;
    end else if (busy_reg) begin
      if (clk_cnt_reg == LAST_CNT) begin
        clk_cnt_reg <= '0;
        if (bit_cnt_reg == LAST_BIT) begin
          busy_reg <= 1'b0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          tx_reg      <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[9:1]};
        end
      end else begin
        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Done fires one cycle early so the next load lands on the last stop-bit cycle.
  assign ser_done = busy_reg && (bit_cnt_reg == LAST_BIT) && (clk_cnt_reg == DONE_CNT);
  assign ser_busy = busy_reg;
  assign tx_out   = tx_reg;

endmodule

// File: rtl/bhargava_link_tx.sv
// Host-side bhargava link initiator: key header, mode byte, data stream, end marker.
module bhargava_link_tx #(
  parameter int    CLK_FREQ  = 200,
  parameter int    BAUD_RATE = 256000,
  parameter string PARITY    = "ODD",
  parameter bit    SEND_KEY  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        mode_in,
  input  logic        start,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        stream_end,
  output logic        tx_out,
  output logic        busy,
  output logic        done
);
  import bhargava_link_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  state_t      state_reg, state_next;
  logic [63:0] key_reg, key_next;
  logic        mode_reg, mode_next;
  logic [2:0]  byte_cnt_reg, byte_cnt_next;
  logic        end_pend_reg, end_pend_next;
  logic        load_pend_reg, load_pend_next;
  logic [7:0]  data_reg, data_next;

  logic        load;
  logic [7:0]  frame_byte;
  logic        par_inv;
  logic        ser_busy;
  logic        ser_done;
  logic        ser_free;
  logic [7:0]  key_bytes [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key_bytes
      assign key_bytes[gi] = key_reg[63-8*gi -: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      key_reg       <= '0;
      mode_reg      <= 1'b0;
      byte_cnt_reg  <= '0;
      end_pend_reg  <= 1'b0;
      load_pend_reg <= 1'b0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= key_next;
      mode_reg      <= mode_next;
      byte_cnt_reg  <= byte_cnt_next;
      end_pend_reg  <= end_pend_next;
      load_pend_reg <= load_pend_next;
      data_reg      <= data_next;
    end
  end

  // load_pend is a one-cycle request: the frame selected by the current state loads next cycle.
  always_comb begin
    state_next     = state_reg;
    key_next       = key_reg;
    mode_next      = mode_reg;
    byte_cnt_next  = byte_cnt_reg;
    end_pend_next  = end_pend_reg;
    load_pend_next = 1'b0;
    data_next      = data_reg;
    load           = 1'b0;
    frame_byte     = 8'h00;
    par_inv        = 1'b0;
    data_ready     = 1'b0;
    done           = 1'b0;
    ser_free       = (!ser_busy || ser_done) && !load_pend_reg;

    if (stream_end && (state_reg == KEY || state_reg == MODE || state_reg == DATA))
      end_pend_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (start) begin
          key_next       = key_in;
          mode_next      = mode_in;
          byte_cnt_next  = '0;
          state_next     = SEND_KEY ? KEY : DATA;
          load_pend_next = SEND_KEY;
        end
      end
      KEY: begin
        load       = load_pend_reg;
        frame_byte = key_bytes[byte_cnt_reg];
        if (ser_done) begin
          load_pend_next = 1'b1;
          if (byte_cnt_reg == 3'd7)
            state_next = MODE;
          else
            byte_cnt_next = byte_cnt_reg + 3'd1;
        end
      end
      MODE: begin
        load       = load_pend_reg;
        frame_byte = {7'b0, mode_reg};
        if (ser_done)
          state_next = DATA;
      end
      DATA: begin
        load       = load_pend_reg;
        frame_byte = data_reg;
        data_ready = ser_free && !end_pend_reg;
        if (data_valid && data_ready) begin
          data_next      = data_in;
          load_pend_next = 1'b1;
        end else if (ser_free && end_pend_reg) begin
          state_next     = END;
          load_pend_next = 1'b1;
        end
      end
      END: begin
        load       = load_pend_reg;
        frame_byte = 8'h00;
        par_inv    = 1'b1;
        if (ser_done)
          state_next = FIN;
      end
      FIN: begin
        if (!ser_busy) begin
          done          = 1'b1;
          end_pend_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  link_frame_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY      (PARITY)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .data_byte(frame_byte),
    .load     (load),
    .par_inv  (par_inv),
    .tx_out   (tx_out),
    .ser_busy (ser_busy),
    .ser_done (ser_done)
  );

endmodule

// File: tb/tb_bhargava_link_tx.sv
// Directed bench: decodes UART frames off tx_out and checks bytes, parity and timing.
module tb_bhargava_link_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        mode_in = 1'b0;

  logic       start_a = 1'b0, valid_a = 1'b0, end_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       ready_a, tx_a, busy_a, done_a;

  logic       start_b = 1'b0, valid_b = 1'b0, end_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       ready_b, tx_b, busy_b, done_b;

  int cyc = 0;
  int ready_cnt = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] hdr_b [9] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01};
  logic       hdr_p [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ready_a === 1'b1) ready_cnt <= ready_cnt + 1;

  bhargava_link_tx #(.CLK_FREQ(1), .BAUD_RATE(100000), .PARITY("ODD"), .SEND_KEY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .key_in(key_in), .mode_in(mode_in), .start(start_a),
    .data_in(data_a), .data_valid(valid_a), .data_ready(ready_a), .stream_end(end_a),
    .tx_out(tx_a), .busy(busy_a), .done(done_a));

  bhargava_link_tx #(.CLK_FREQ(1), .BAUD_RATE(100000), .PARITY("EVEN"), .SEND_KEY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in), .mode_in(mode_in), .start(start_b),
    .data_in(data_b), .data_valid(valid_b), .data_ready(ready_b), .stream_end(end_b),
    .tx_out(tx_b), .busy(busy_b), .done(done_b));

  function automatic logic txs(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction
  function automatic logic rdy(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic dn(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction
  function automatic logic bsy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns at mid stop bit; t_fall is the first cycle the start bit is seen.
  task automatic rx_frame(input int sel, input string tag, output logic [7:0] b,
                          output logic p, output logic s, output int t_fall);
    int n;
    n = 0;
    b = 'x; p = 1'bx; s = 1'bx; t_fall = -1;
    while (txs(sel) !== 1'b0 && n < 400) begin step(); n++; end
    chk1({tag, "_wait"}, n < 400, 1'b1);
    if (n >= 400) return;
    t_fall = cyc;
    repeat (5) step();
    for (int i = 0; i < 8; i++) begin
      repeat (10) step();
      b[i] = txs(sel);
    end
    repeat (10) step();
    p = txs(sel);
    repeat (10) step();
    s = txs(sel);
  endtask

  task automatic wait_ready(input int sel, input string tag, output int t);
    int n;
    n = 0;
    while (rdy(sel) !== 1'b1 && n < 400) begin step(); n++; end
    chk1({tag, "_wait"}, n < 400, 1'b1);
    t = cyc;
  endtask

  task automatic check_done(input int sel, input string tag, input int fe);
    int done_cyc, done_cnt;
    logic busy_at_done;
    done_cyc = -1; done_cnt = 0; busy_at_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dn(sel) === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = bsy(sel);
        end
      end
    end
    chk32({tag, "_done_lat"}, done_cyc - fe, 110);
    chk32({tag, "_done_cnt"}, done_cnt, 1);
    chk1({tag, "_busy_at_done"}, busy_at_done, 1'b1);
    chk1({tag, "_busy_after"}, bsy(sel), 1'b0);
  endtask

  task automatic run_header(input int t_start, output int t_last);
    logic [7:0] b;
    logic p, s;
    int tf, prev;
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      rx_frame(0, $sformatf("hdr%0d", i), b, p, s, tf);
      chk8($sformatf("hdr%0d_byte", i), b, hdr_b[i]);
      chk1($sformatf("hdr%0d_par", i), p, hdr_p[i]);
      chk1($sformatf("hdr%0d_stop", i), s, 1'b1);
      if (i == 0) chk32("hdr0_lat", tf - t_start, 2);
      else        chk32($sformatf("hdr%0d_gap", i), tf - prev, 110);
      chk1($sformatf("hdr%0d_busy", i), busy_a, 1'b1);
      prev = tf;
    end
    t_last = prev;
  endtask

  initial begin
    int s_cyc, t_last, r0, rc, rc2, fa, f3, fe, f7, n;
    logic [7:0] b;
    logic p, s;

    repeat (3) step();
    chk1("rst_tx", tx_a, 1'b1);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_ready", ready_a, 1'b0);
    chk1("rst_done", done_a, 1'b0);
    chk1("rst_tx_b", tx_b, 1'b1);
    rst = 1'b0;
    step();

    // Key header and mode byte
    key_in = 64'h0123456789ABCDEF; mode_in = 1'b1;
    s_cyc = cyc; start_a = 1'b1; step(); start_a = 1'b0;
    run_header(s_cyc, t_last);

    // Data handshake with valid held high
    r0 = ready_cnt; data_a = 8'hA5; valid_a = 1'b1;
    wait_ready(0, "rdy_a5", rc);
    chk32("rdy_a5_lat", rc - t_last, 110);
    step(); data_a = 8'h3C;
    rx_frame(0, "a5", b, p, s, fa);
    chk8("a5_byte", b, 8'hA5);
    chk1("a5_par", p, 1'b1);
    chk32("a5_lat", fa - rc, 2);
    wait_ready(0, "rdy_3c", rc2);
    chk32("rdy_3c_lat", rc2 - fa, 108);
    step(); valid_a = 1'b0;
    chk32("ready_cycles", ready_cnt - r0, 2);
    rx_frame(0, "3c", b, p, s, f3);
    chk8("3c_byte", b, 8'h3C);
    chk1("3c_par", p, 1'b1);
    chk32("3c_gap", f3 - fa, 110);

    // End marker with serializer idle
    repeat (10) step();
    chk1("end_idle_ready", ready_a, 1'b1);
    s_cyc = cyc; end_a = 1'b1; step(); end_a = 1'b0;
    chk1("end_pend_ready", ready_a, 1'b0);
    rx_frame(0, "endm", b, p, s, fe);
    chk8("endm_byte", b, 8'h00);
    chk1("endm_par", p, 1'b0);
    chk1("endm_stop", s, 1'b1);
    chk32("endm_lat", fe - s_cyc, 3);
    check_done(0, "a1", fe);

    // Reset in the middle of the first key frame
    s_cyc = cyc; start_a = 1'b1; step(); start_a = 1'b0;
    n = 0;
    while (tx_a !== 1'b0 && n < 50) begin step(); n++; end
    chk32("mid_fall_lat", cyc - s_cyc, 2);
    repeat (45) step();
    chk1("mid_bit4_low", tx_a, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("mid_rst_tx", tx_a, 1'b1);
    chk1("mid_rst_busy", busy_a, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    chk1("mid_post_tx", tx_a, 1'b1);
    s_cyc = cyc; start_a = 1'b1; step(); start_a = 1'b0;
    run_header(s_cyc, t_last);

    // Byte accepted in the same cycle as stream_end
    wait_ready(0, "rdy_7e", rc);
    data_a = 8'h7E; valid_a = 1'b1; end_a = 1'b1;
    step();
    valid_a = 1'b0; end_a = 1'b0;
    rx_frame(0, "7e", b, p, s, f7);
    chk8("7e_byte", b, 8'h7E);
    chk1("7e_par", p, 1'b1);
    rx_frame(0, "endm2", b, p, s, fe);
    chk8("endm2_byte", b, 8'h00);
    chk1("endm2_par", p, 1'b0);
    chk32("endm2_gap", fe - f7, 110);
    check_done(0, "a2", fe);

    // No header, even parity
    start_b = 1'b1; step(); start_b = 1'b0;
    chk1("b_busy", busy_b, 1'b1);
    chk1("b_ready", ready_b, 1'b1);
    data_b = 8'h01; valid_b = 1'b1; step(); valid_b = 1'b0;
    rx_frame(1, "b01", b, p, s, fa);
    chk8("b01_byte", b, 8'h01);
    chk1("b01_par", p, 1'b1);
    chk1("b01_stop", s, 1'b1);
    repeat (10) step();
    chk1("b_idle_ready", ready_b, 1'b1);
    end_b = 1'b1; step(); end_b = 1'b0;
    rx_frame(1, "bend", b, p, s, fe);
    chk8("bend_byte", b, 8'h00);
    chk1("bend_par", p, 1'b1);
    check_done(1, "b", fe);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
